systolic_matmul_host: RTL
=========================

# systolic_matmul_host

Host-side initiator for the 2x2 systolic matmul tile (`tt_um_systolic_matmul`, the "tile"). It accepts a pair of 2x2 4-bit matrices over a valid/ready request port and drives them onto the tile's `ui_in`/`uio_in` pins at the exact cycles the tile samples them. It then captures the two-beat result burst from `uo_out`/`uio_out` and returns the unpacked 2x2 8-bit product on a valid/ready response port. Internally it runs a cycle-exact shadow copy of the tile's state machine, because the tile has no handshake of its own.

## Interface
- No parameters; the block is sized for the 2x2 tile only.
- `clk`  in  1  sole clock, shared with the tile.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are both high on the same edge.
- `req_a`  in  16  A = {A00, A01, A10, A11}, 4 bits each.
- `req_b`  in  16  B = {B00, B01, B10, B11}, 4 bits each.
- `rsp_valid`  out  1  response present; held until the response is accepted.
- `rsp_ready`  in  1  response consumed when `rsp_valid` and `rsp_ready` are both high on the same edge.
- `rsp_c`  out  32  C = {C00, C01, C10, C11}, 8 bits each.
- `rsp_err`  out  1  request rejected (a matrix has an all-zero row).
- `sync_err`  out  1  sticky flag: tile behaviour differed from the shadow FSM.
- `dut_rst_n`  out  1  registered active-low reset to the tile.
- `dut_ui`  out  8  registered, drives tile `ui_in`.
- `dut_uio`  out  8  registered, drives tile `uio_in`.
- `dut_uo`  in  8  from tile `uo_out`.
- `dut_uio_out`  in  8  from tile `uio_out`.
- `dut_uio_oe`  in  8  from tile `uio_oe`.

## Operation
- **Reset values.** `req_ready`=0, `rsp_valid`=0, `rsp_c`=0, `rsp_err`=0, `sync_err`=0, `dut_rst_n`=0, `dut_ui`=0, `dut_uio`=0. Shadow state = RST.
- **Shadow FSM.** States are RST, IDLE, LA, SA, CA, LB, SB, CB, K0, K1, K2, O1, O2.
  - RST→IDLE on the first edge with `rst`=0; that same edge sets `dut_rst_n`=1.
  - Fixed chain: IDLE→LA→SA→CA.
  - CA→LB if the last LA issued a matrix, else CA→LA. This models the tile looping while it sees an invalid A.
  - Fixed chain: LB→SB→CB→K0→K1→K2→O1→O2→IDLE.
- **Request buffer.** Holds one request. `req_ready`=1 only when no request is held and no response is pending.
- **Pre-check on accept.** If A or B has an all-zero row, the request is never issued. Next cycle: `rsp_valid`=1, `rsp_err`=1, `rsp_c`=0.
- **Issue A.** On an edge entering LA with a held, unissued, valid request: `dut_ui`={A00,A01}, `dut_uio`={A10,A11}. Otherwise `dut_ui`/`dut_uio` are 0 during LA, and the tile stays in the LA/SA/CA loop.
- **Issue B.** On the edge entering LB: `dut_ui`={B00,B01}, `dut_uio`={B10,B11}.
- **Pins outside LA/LB.** `dut_ui` and `dut_uio` are 0 in every other shadow state.
- **Capture, row 0.** During O2: C00={`dut_uio_out[7:4]`,`dut_uo[7:4]`}, C01={`dut_uio_out[3:0]`,`dut_uo[3:0]`}.
- **Capture, row 1.** During the following IDLE: C10 and C11 are rebuilt the same way.
- **Response.** `rsp_valid`=1, `rsp_err`=0 on the edge leaving IDLE. The request buffer frees on the response handshake.
- **Width rule.** Each C entry is 8 bits, the tile's value modulo 256 (largest true sum is 450). No recomputation or correction.
- **sync_err set conditions** (cleared only by `rst`):
  - `dut_uio_oe`≠0xFF during O2 or the capture IDLE.
  - `dut_uio_oe`≠0x00 during LA or LB.
- **Reset mid-operation.**
  - Any held request and partial capture are discarded.
  - No response is produced for it.
  - `dut_rst_n` drops on that same edge, so the tile and the shadow FSM restart aligned.

## Timing
- **Accept to issue.** The accept edge strictly precedes the LA-entry edge that issues it: 1–3 cycles in the idle loop, up to 12 while a prior frame completes.
- **Frame length.** LA entry to `rsp_valid`: 12 edges.
- **Accept to response.** Total `req` handshake to `rsp_valid` is 13–15 cycles from idle.
- **Rejected request.** `rsp_valid` follows the accept edge by 1 cycle.
- **Throughput.** One request in flight. The next accept is possible on the cycle after the response handshake.
- **Back-pressure.** With `rsp_ready` held low, `rsp_*` stay stable and `req_ready` stays 0. The shadow FSM keeps running, with A/B pins at 0.

## Test plan
- **Basic product.** A=0x1234, B=0x5678 with `rsp_ready`=1 → `rsp_c`=0x13162B32, `rsp_err`=0, `rsp_valid` 13–15 cycles after accept, `sync_err`=0.
- **Overflow wrap.** A=0xFFFF, B=0xFFFF → `rsp_c`=0xC2C2C2C2 (450 mod 256 per entry).
- **Zero-row reject.** A=0x1200 → `rsp_err`=1, `rsp_c`=0 one cycle after accept. `dut_ui`/`dut_uio` stay 0 and the tile never leaves the LA loop.
- **Back-pressure.** `rsp_ready`=0 for 5 cycles after `rsp_valid`: `rsp_c` stable, `req_ready`=0. After the handshake, a second request with A=0x1111, B=0x1111 → 0x02020202.
- **Reset mid-frame.** Assert `rst` for 1 cycle while the shadow FSM is in K1 → no response, `dut_rst_n`=0 for one cycle. A new request with A=0x1234, B=0x5678 then returns 0x13162B32.
- **Desync detection.** Force `dut_uio_oe`=0x00 during O2 → `sync_err`=1, held through later frames until `rst`.

Source files
------------

// File: rtl/systolic_matmul_host.sv
// Host initiator for the 2x2 systolic matmul tile: shadows the tile FSM cycle-exactly,
// drives A/B onto the tile pins at its sample cycles and returns the captured product.
module systolic_matmul_host (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_err,
  output logic        sync_err,
  output logic        dut_rst_n,
  output logic [7:0]  dut_ui,
  output logic [7:0]  dut_uio,
  input  logic [7:0]  dut_uo,
  input  logic [7:0]  dut_uio_out,
  input  logic [7:0]  dut_uio_oe
);

  typedef enum logic [3:0] {
    S_RST, S_IDLE, S_LA, S_SA, S_CA, S_LB, S_SB, S_CB,
    S_K0, S_K1, S_K2, S_O1, S_O2
  } state_t;

  state_t      st, st_nxt;
  logic        held, issued, la_hit, cap;
  logic [15:0] a_q, b_q, row0;
  logic        enter_la, issue, accept, zero_row;
  logic [15:0] row_now;

  always_ff @(posedge clk) begin
    if (rst) st <= S_RST;
    else     st <= st_nxt;
  end

  // CA branches on whether the tile saw a valid A at its last LA
  always_comb begin
    st_nxt = st;
    case (st)
      S_RST:   st_nxt = S_IDLE;
      S_IDLE:  st_nxt = S_LA;
      S_LA:    st_nxt = S_SA;
      S_SA:    st_nxt = S_CA;
      S_CA:    st_nxt = la_hit ? S_LB : S_LA;
      S_LB:    st_nxt = S_SB;
      S_SB:    st_nxt = S_CB;
      S_CB:    st_nxt = S_K0;
      S_K0:    st_nxt = S_K1;
      S_K1:    st_nxt = S_K2;
      S_K2:    st_nxt = S_O1;
      S_O1:    st_nxt = S_O2;
      S_O2:    st_nxt = S_IDLE;
      default: st_nxt = S_RST;
    endcase
  end

  assign req_ready = (st != S_RST) && !held && !rsp_valid;
  assign accept    = req_valid && req_ready;
  assign zero_row  = (req_a[15:8] == 8'h00) || (req_a[7:0] == 8'h00) ||
                     (req_b[15:8] == 8'h00) || (req_b[7:0] == 8'h00);
  assign enter_la  = (st_nxt == S_LA);
  assign issue     = enter_la && held && !issued;
  // Tile presents low nibbles on uo and high nibbles on uio_out
  assign row_now   = {dut_uio_out[7:4], dut_uo[7:4], dut_uio_out[3:0], dut_uo[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_rst_n <= 1'b0;
      dut_ui    <= 8'h00;
      dut_uio   <= 8'h00;
      held      <= 1'b0;
      issued    <= 1'b0;
      la_hit    <= 1'b0;
      cap       <= 1'b0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      row0      <= 16'h0000;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_c     <= 32'h0;
      sync_err  <= 1'b0;
    end else begin
      dut_rst_n <= 1'b1;
      dut_ui    <= 8'h00;
      dut_uio   <= 8'h00;
      cap       <= (st == S_O2);

      if (enter_la) la_hit <= issue;
      if (issue) begin
        dut_ui  <= a_q[15:8];
        dut_uio <= a_q[7:0];
        issued  <= 1'b1;
      end
      if (st_nxt == S_LB) begin
        dut_ui  <= b_q[15:8];
        dut_uio <= b_q[7:0];
      end

      if (st == S_O2) row0 <= row_now;
      if (st == S_IDLE && cap) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_c     <= {row0, row_now};
      end

      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        held      <= 1'b0;
      end

      // Rejected requests never occupy the buffer; the pending response blocks new ones
      if (accept) begin
        if (zero_row) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_c     <= 32'h0;
        end else begin
          held   <= 1'b1;
          issued <= 1'b0;
          a_q    <= req_a;
          b_q    <= req_b;
        end
      end

      if (((st == S_O2) || (st == S_IDLE && cap)) && dut_uio_oe != 8'hFF) sync_err <= 1'b1;
      if (((st == S_LA) || (st == S_LB)) && dut_uio_oe != 8'h00)           sync_err <= 1'b1;
    end
  end

endmodule
